csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Machine-mode CSR file: M-mode registers, 64-bit cycle/instret/HPM counters, trap entry/mret sequencing.
//  Address/op arrive in EX; registered read data and illegal flag are valid in MEM (1 cycle later).
//  Feeds mtvec/mepc/MIE to the fetch/trap logic.
// PARAMETERS
//  NUM_HPM      4             implemented mhpmcounter3..(3+NUM_HPM-1), range 0..29
//  HARTID       0             value returned by mhartid
//  MTVEC_RESET  32'h0000_0000 reset value of mtvec (bits [1:0] forced 0)
//  MISA_VAL     32'h4000_0100 read-only misa value (RV32I)
// PORTS
//  clk_i          in   1        clock
//  rst_i          in   1        async reset, active-high
//  csr_addr_i     in   12       CSR address (EX stage)
//  csr_op_i       in   2        csr_op_t: NONE / READ_WRITE / SET / CLR
//  csr_wdata_i    in   32       write/set/clear operand
//  csr_rdata_o    out  32       registered old value of addressed CSR
//  illegal_o      out  1        registered illegal-access flag
//  trap_i         in   1        take trap this cycle
//  trap_cause_i   in   32       mcause value on trap
//  trap_pc_i      in   32       faulting PC
//  trap_tval_i    in   32       mtval value on trap
//  mret_i         in   1        mret retiring
//  instret_i      in   1        one instruction retired
//  hpm_event_i    in   NUM_HPM  per-counter increment strobe
//  mtvec_o        out  32       current mtvec
//  mepc_o         out  32       current mepc
//  mie_o          out  1        mstatus.MIE
// BEHAVIOUR
//  - Reset: all CSRs 0, except mtvec=MTVEC_RESET and mstatus.MPP=2'b11 (hardwired). Outputs: rdata 0, illegal 0, mtvec_o=MTVEC_RESET, mepc_o 0, mie_o 0. Reset mid-op discards pending write/trap.
//  - Map: F11-F14 vendorid/archid/impid/hartid (RO, 0/0/0/HARTID); 300 mstatus; 301 misa (writes ignored);
//    304 mie; 305 mtvec; 306 mcounteren; 320 mcountinhibit; 340-344 mscratch/mepc/mcause/mtval/mip;
//    B00/B80 mcycle(h); B02/B82 minstret(h); B03-B1F / B83-B9F mhpmcounterN(h).
//  - HPM N >= 3+NUM_HPM: legal, read 0, writes dropped.
//  - mip: reads 0, writes dropped.
//  - Read: csr_rdata_o <= pre-update value, latency 1. op==NONE still updates rdata; illegal <= 0.
//  - Write: RW: new=wdata; SET: old|wdata; CLR: old&~wdata. Commits at the same edge rdata is registered.
//  - Illegal (illegal_o<=1 next cycle, no state change, rdata<=0): op!=NONE and the address is unmapped, or op!=NONE and addr[11:10]==2'b11.
//  - Bit fields that ignore writes:
//    - mstatus: only MIE[3], MPIE[7] writable; MPP reads 2'b11; all other bits 0.
//    - mtvec[1:0] and mepc[1:0] read 0.
//    - mcountinhibit: only bits 0, 2 and 3..3+NUM_HPM-1 writable.
//  - Counters: each edge mcycle+=1 unless inhibit[0]; minstret+=instret_i unless inhibit[2]; hpmN+=hpm_event_i unless inhibit[N].
//    - 64-bit wrap FFFF_FFFF_FFFF_FFFF -> 0. Low-half carry propagates into the high half.
//    - Writing one half replaces that half only; the same-cycle increment of that counter is suppressed.
//  - Trap (trap_i): mepc<=trap_pc_i&~3, mcause<=trap_cause_i, mtval<=trap_tval_i, MPIE<=MIE, MIE<=0.
//  - mret_i: MIE<=MPIE, MPIE<=1.
//  - Same-cycle priority: trap_i > mret_i > CSR write.
//    - With trap or mret, a CSR write to mstatus/mepc/mcause/mtval is dropped.
//    - Writes to other CSRs still commit; rdata is still registered.
// STRUCTURE
//  - proc_pkg: csr_op_t, CSR address localparams, MSTATUS_MIE/MPIE/MPP bit indices.
//  - Sub-module csr_counter64: 64-bit counter with inc/inhibit, lo/hi write, write-beats-increment.
//    Instantiated 2+NUM_HPM times.
//  - Everything else (decode, WARL masks, trap sequencing) lives in this module.
// TESTING
//  1. Reset, then idle 10 cycles, read B00 -> rdata=10 (±1 for read latency); F14 reads HARTID; illegal_o=0.
//  2. RW 340 with 0xDEADBEEF, then SET 0x0000_0010, then CLR 0xDEAD_0000 -> reads 0xDEADBEEF, 0xDEADBEFF, 0x0000BEFF.
//  3. RW to F11, or SET to unmapped 0x7C0 -> illegal_o=1 next cycle, rdata=0, no CSR changes; op=NONE on 0x7C0 -> illegal_o=0.
//  4. Write mcycle=0xFFFF_FFFF, mcycleh=0x1 -> next cycles read B80=0x2, B00 wraps to 0.
//     Set mcountinhibit=0x1 -> mcycle frozen.
//  5. MIE=1, trap_i with pc=0x103, cause=2 -> mepc_o=0x100, mcause=2, MIE=0, MPIE=1; then mret_i -> MIE=1, MPIE=1.
//  6. trap_i together with RW mepc=0x500 -> mepc=trap PC, write dropped; RW mscratch in the same cycle still commits.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// csr_unit_pkg: shared CSR operation type, address map and mstatus field positions
package csr_unit_pkg;
   typedef enum logic [1:0] {
      CSR_NONE = 2'd0,
      CSR_RW   = 2'd1,
      CSR_SET  = 2'd2,
      CSR_CLR  = 2'd3
   } csr_op_t;
   localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
   localparam logic [11:0] CSR_MARCHID       = 12'hF12;
   localparam logic [11:0] CSR_MIMPID        = 12'hF13;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;
   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;
endpackage

// File: rtl/csr_unit_counter64.sv
// csr_unit_counter64: 64-bit event counter with half-word writes that override the increment
module csr_unit_counter64 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        inhibit_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] cnt_o
);
   // a half-word write replaces only its half and swallows this cycle's increment
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_o <= '0;
      else if (wr_lo_i) cnt_o[31:0] <= wdata_i;
      else if (wr_hi_i) cnt_o[63:32] <= wdata_i;
      else if (inc_i && !inhibit_i) cnt_o <= cnt_o + 64'd1;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with 64-bit counters and trap/mret sequencing
module csr_unit
   import csr_unit_pkg::*;
#(
   parameter int unsigned NUM_HPM     = 4,
   parameter logic [31:0] HARTID      = 32'h0000_0000,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [11:0]        csr_addr_i,
   input  logic [1:0]         csr_op_i,
   input  logic [31:0]        csr_wdata_i,
   output logic [31:0]        csr_rdata_o,
   output logic               illegal_o,
   input  logic               trap_i,
   input  logic [31:0]        trap_cause_i,
   input  logic [31:0]        trap_pc_i,
   input  logic [31:0]        trap_tval_i,
   input  logic               mret_i,
   input  logic               instret_i,
   input  logic [NUM_HPM-1:0] hpm_event_i,
   output logic [31:0]        mtvec_o,
   output logic [31:0]        mepc_o,
   output logic               mie_o
);
   localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [31:0] INHIBIT_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
   csr_op_t     op;
   logic        mie_q, mpie_q;
   logic [31:0] mie_csr_q, mcounteren_q, minhibit_q, mscratch_q, mcause_q, mtval_q;
   logic [31:2] mtvec_q, mepc_q;
   logic [63:0] cyc_q, ins_q, cnt_sel;
   logic [63:0] hpm_q [HPM_N];
   logic [31:0] old_val, new_val;
   logic        mapped, illegal, we, cnt_we, is_cnt;
   logic [4:0]  cnt_n;
   assign op      = csr_op_t'(csr_op_i);
   assign is_cnt  = csr_addr_i[11:8] == 4'hB && csr_addr_i[6:5] == 2'b00;
   assign cnt_n   = csr_addr_i[4:0];
   assign illegal = op != CSR_NONE && (!mapped || csr_addr_i[11:10] == 2'b11);
   assign we      = op != CSR_NONE && !illegal;
   assign cnt_we  = we && is_cnt;
   assign new_val = op == CSR_RW ? csr_wdata_i : op == CSR_SET ? old_val | csr_wdata_i : old_val & ~csr_wdata_i;
   assign mtvec_o = {mtvec_q, 2'b00};
   assign mepc_o  = {mepc_q, 2'b00};
   assign mie_o   = mie_q;
   // address decode: current value of the addressed CSR and whether it exists
   always_comb begin
      old_val = '0;
      mapped  = 1'b1;
      cnt_sel = cnt_n == 5'd0 ? cyc_q : cnt_n == 5'd2 ? ins_q : '0;
      for (int j = 0; j < NUM_HPM; j++)
         if (int'(cnt_n) == j + 3) cnt_sel = hpm_q[j];
      case (csr_addr_i)
         CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MIP: old_val = '0;
         CSR_MHARTID:       old_val = HARTID;
         CSR_MSTATUS: begin
            old_val[MSTATUS_MIE]       = mie_q;
            old_val[MSTATUS_MPIE]      = mpie_q;
            old_val[MSTATUS_MPP +: 2]  = 2'b11;
         end
         CSR_MISA:          old_val = MISA_VAL;
         CSR_MIE:           old_val = mie_csr_q;
         CSR_MTVEC:         old_val = mtvec_o;
         CSR_MCOUNTEREN:    old_val = mcounteren_q;
         CSR_MCOUNTINHIBIT: old_val = minhibit_q;
         CSR_MSCRATCH:      old_val = mscratch_q;
         CSR_MEPC:          old_val = mepc_o;
         CSR_MCAUSE:        old_val = mcause_q;
         CSR_MTVAL:         old_val = mtval_q;
         default:
            if (is_cnt && cnt_n != 5'd1) old_val = csr_addr_i[7] ? cnt_sel[63:32] : cnt_sel[31:0];
            else mapped = 1'b0;
      endcase
   end
   // register read result, commit CSR writes, then let trap/mret override the trap-state CSRs
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         csr_rdata_o  <= '0;
         illegal_o    <= 1'b0;
         mie_q        <= 1'b0;
         mpie_q       <= 1'b0;
         mie_csr_q    <= '0;
         mtvec_q      <= MTVEC_RESET[31:2];
         mcounteren_q <= '0;
         minhibit_q   <= '0;
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
      end else begin
         csr_rdata_o <= illegal ? '0 : old_val;
         illegal_o   <= illegal;
         if (we)
            case (csr_addr_i)
               CSR_MIE:           mie_csr_q    <= new_val;
               CSR_MTVEC:         mtvec_q      <= new_val[31:2];
               CSR_MCOUNTEREN:    mcounteren_q <= new_val;
               CSR_MCOUNTINHIBIT: minhibit_q   <= new_val & INHIBIT_MASK;
               CSR_MSCRATCH:      mscratch_q   <= new_val;
               default: ;
            endcase
         if (we && !trap_i && !mret_i)
            case (csr_addr_i)
               CSR_MSTATUS: begin
                  mie_q  <= new_val[MSTATUS_MIE];
                  mpie_q <= new_val[MSTATUS_MPIE];
               end
               CSR_MEPC:   mepc_q   <= new_val[31:2];
               CSR_MCAUSE: mcause_q <= new_val;
               CSR_MTVAL:  mtval_q  <= new_val;
               default: ;
            endcase
         if (trap_i) begin
            mepc_q   <= trap_pc_i[31:2];
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_tval_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end
      end
   csr_unit_counter64 u_mcycle (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (1'b1),
      .inhibit_i(minhibit_q[0]),
      .wr_lo_i  (cnt_we && cnt_n == 5'd0 && !csr_addr_i[7]),
      .wr_hi_i  (cnt_we && cnt_n == 5'd0 && csr_addr_i[7]),
      .wdata_i  (new_val),
      .cnt_o    (cyc_q)
   );
   csr_unit_counter64 u_minstret (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc_i    (instret_i),
      .inhibit_i(minhibit_q[2]),
      .wr_lo_i  (cnt_we && cnt_n == 5'd2 && !csr_addr_i[7]),
      .wr_hi_i  (cnt_we && cnt_n == 5'd2 && csr_addr_i[7]),
      .wdata_i  (new_val),
      .cnt_o    (ins_q)
   );
   for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
      csr_unit_counter64 u_hpm (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .inc_i    (hpm_event_i[g]),
         .inhibit_i(minhibit_q[g+3]),
         .wr_lo_i  (cnt_we && cnt_n == 5'(g + 3) && !csr_addr_i[7]),
         .wr_hi_i  (cnt_we && cnt_n == 5'(g + 3) && csr_addr_i[7]),
         .wdata_i  (new_val),
         .cnt_o    (hpm_q[g])
      );
   end
   if (NUM_HPM == 0) begin : g_no_hpm
      assign hpm_q[0] = '0;
   end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: randomized and directed checks of csr_unit against a behavioural CSR model
module tb_csr_unit;
   localparam int          NH  = 4;
   localparam logic [31:0] HID = 32'h0000_0005;
   localparam logic [31:0] MTV = 32'h8000_0103;
   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [11:0]   csr_addr_i;
   logic [1:0]    csr_op_i;
   logic [31:0]   csr_wdata_i, csr_rdata_o;
   logic          illegal_o;
   logic          trap_i, mret_i, instret_i, mie_o;
   logic [31:0]   trap_cause_i, trap_pc_i, trap_tval_i, mtvec_o, mepc_o;
   logic [NH-1:0] hpm_event_i;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk_i = ~clk_i;
   csr_unit #(.NUM_HPM(NH), .HARTID(HID), .MTVEC_RESET(MTV)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .illegal_o(illegal_o),
      .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i),
      .mret_i(mret_i), .instret_i(instret_i), .hpm_event_i(hpm_event_i),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
   );
   // reference model state: architectural values only
   logic        m_mie, m_mpie;
   logic [31:0] m_mie_csr, m_mtvec, m_mcen, m_minh, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cnt [NH+2];
   logic [31:0] e_rdata;
   logic        e_ill;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic m_reset();
      m_mie = 0; m_mpie = 0; m_mie_csr = 0; m_mtvec = MTV & ~32'h3; m_mcen = 0; m_minh = 0;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; e_rdata = 0; e_ill = 0;
      for (int k = 0; k < NH + 2; k++) m_cnt[k] = 0;
   endtask
   // counter index: -1 not a counter address, -2 legal but unimplemented, else model slot
   function automatic int cnt_idx(input logic [11:0] a, output logic hi);
      int n;
      hi = a >= 12'hB80;
      if (!((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F))) return -1;
      n = int'(a & 12'h1F);
      if (n == 0) return 0;
      if (n == 1) return -1;
      if (n == 2) return 1;
      return (n - 3 < NH) ? n - 1 : -2;
   endfunction
   function automatic logic [31:0] m_read(input logic [11:0] a, output logic ok);
      logic hi;
      int k;
      ok = 1;
      case (a)
         12'hF11, 12'hF12, 12'hF13, 12'h344: return 0;
         12'hF14: return HID;
         12'h300: return ({31'b0, m_mie} << 3) | ({31'b0, m_mpie} << 7) | 32'h1800;
         12'h301: return 32'h4000_0100;
         12'h304: return m_mie_csr;
         12'h305: return m_mtvec;
         12'h306: return m_mcen;
         12'h320: return m_minh;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: begin
            k = cnt_idx(a, hi);
            if (k == -1) begin ok = 0; return 0; end
            if (k == -2) return 0;
            return hi ? m_cnt[k][63:32] : m_cnt[k][31:0];
         end
      endcase
   endfunction
   // drive one cycle, advance the model, then compare after the edge
   task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w,
                       input logic tr, input logic mr, input logic [31:0] pc, input logic [31:0] cause,
                       input logic [31:0] tval, input logic ir, input logic [NH-1:0] ev);
      logic ok, ill, busy, hi;
      logic [31:0] old, nv, inh;
      logic wr [NH+2];
      logic inc [NH+2];
      int k, ib;
      csr_addr_i = a; csr_op_i = op; csr_wdata_i = w; trap_i = tr; mret_i = mr; trap_pc_i = pc;
      trap_cause_i = cause; trap_tval_i = tval; instret_i = ir; hpm_event_i = ev;
      old = m_read(a, ok);
      ill = op != 2'd0 && (!ok || a[11:10] == 2'b11);
      e_rdata = ill ? 0 : old;
      e_ill = ill;
      inh = m_minh;
      busy = tr | mr;
      for (int i = 0; i < NH + 2; i++) begin
         wr[i] = 0;
         inc[i] = i == 0 ? 1'b1 : i == 1 ? ir : ev[i-2];
      end
      if (op != 2'd0 && !ill) begin
         nv = op == 2'd1 ? w : op == 2'd2 ? old | w : old & ~w;
         case (a)
            12'h300: if (!busy) begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_mie_csr = nv;
            12'h305: m_mtvec = nv & ~32'h3;
            12'h306: m_mcen = nv;
            12'h320: m_minh = nv & 32'h0000_007D;
            12'h340: m_mscratch = nv;
            12'h341: if (!busy) m_mepc = nv & ~32'h3;
            12'h342: if (!busy) m_mcause = nv;
            12'h343: if (!busy) m_mtval = nv;
            default: begin
               k = cnt_idx(a, hi);
               if (k >= 0) begin
                  if (hi) m_cnt[k][63:32] = nv; else m_cnt[k][31:0] = nv;
                  wr[k] = 1;
               end
            end
         endcase
      end
      for (int i = 0; i < NH + 2; i++) begin
         ib = i == 0 ? 0 : i == 1 ? 2 : i + 1;
         if (!wr[i] && inc[i] && !inh[ib]) m_cnt[i] = m_cnt[i] + 64'd1;
      end
      if (tr) begin
         m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = tval; m_mpie = m_mie; m_mie = 0;
      end else if (mr) begin
         m_mie = m_mpie; m_mpie = 1;
      end
      @(posedge clk_i);
      #1;
      chk("rdata", csr_rdata_o, e_rdata);
      chk("illegal", {31'b0, illegal_o}, {31'b0, e_ill});
      chk("mtvec", mtvec_o, m_mtvec);
      chk("mepc", mepc_o, m_mepc);
      chk("mie", {31'b0, mie_o}, {31'b0, m_mie});
   endtask
   task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
      step(a, op, w, 0, 0, 0, 0, 0, 0, '0);
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_rdata"}, csr_rdata_o, 32'h0);
      chk({tag, "_illegal"}, {31'b0, illegal_o}, 32'h0);
      chk({tag, "_mtvec"}, mtvec_o, 32'h8000_0100);
      chk({tag, "_mepc"}, mepc_o, 32'h0);
      chk({tag, "_mie"}, {31'b0, mie_o}, 32'h0);
   endtask
   logic [11:0] pool [27] = '{12'hF11, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h320,
                              12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hB03, 12'hB83, 12'hB06, 12'hB86, 12'hB07, 12'hB87, 12'hB1F,
                              12'hB01, 12'h7C0, 12'hC00};
   initial begin
      logic [31:0] frozen;
      rst_i = 1; csr_addr_i = 0; csr_op_i = 0; csr_wdata_i = 0; trap_i = 0; mret_i = 0;
      trap_cause_i = 0; trap_pc_i = 0; trap_tval_i = 0; instret_i = 0; hpm_event_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_reset("reset");
      rst_i = 0;
      m_reset();
      repeat (10) csr(12'h000, 2'd0, 0);
      csr(12'hB00, 2'd0, 0);
      chk("idle_mcycle", csr_rdata_o, 32'd10);
      csr(12'hF14, 2'd0, 0);
      chk("hartid", csr_rdata_o, HID);
      csr(12'h340, 2'd1, 32'hDEAD_BEEF);
      csr(12'h340, 2'd2, 32'h0000_0010);
      chk("rw_then_set", csr_rdata_o, 32'hDEAD_BEEF);
      csr(12'h340, 2'd3, 32'hDEAD_0000);
      chk("set_then_clr", csr_rdata_o, 32'hDEAD_BEFF);
      csr(12'h340, 2'd0, 0);
      chk("after_clr", csr_rdata_o, 32'h0000_BEFF);
      csr(12'hF11, 2'd1, 32'h1);
      chk("ro_illegal", {31'b0, illegal_o}, 32'h1);
      csr(12'h7C0, 2'd2, 32'hFFFF_FFFF);
      chk("unmapped_illegal", {31'b0, illegal_o}, 32'h1);
      chk("unmapped_rdata", csr_rdata_o, 32'h0);
      csr(12'h7C0, 2'd0, 0);
      chk("unmapped_none", {31'b0, illegal_o}, 32'h0);
      csr(12'h340, 2'd0, 0);
      chk("no_side_effect", csr_rdata_o, 32'h0000_BEFF);
      csr(12'hB00, 2'd1, 32'hFFFF_FFFF);
      csr(12'hB80, 2'd1, 32'h1);
      csr(12'hB80, 2'd0, 0);
      csr(12'hB80, 2'd0, 0);
      chk("mcycleh_carry", csr_rdata_o, 32'h2);
      csr(12'hB00, 2'd0, 0);
      chk("mcycle_wrapped", csr_rdata_o, 32'h1);
      csr(12'h320, 2'd1, 32'h1);
      csr(12'hB00, 2'd0, 0);
      frozen = csr_rdata_o;
      repeat (3) csr(12'hB00, 2'd0, 0);
      chk("mcycle_frozen", csr_rdata_o, frozen);
      csr(12'h320, 2'd1, 32'h0);
      csr(12'h300, 2'd1, 32'h8);
      step(12'h000, 2'd0, 0, 1, 0, 32'h103, 32'h2, 32'h55, 0, '0);
      chk("trap_mepc", mepc_o, 32'h100);
      chk("trap_mie", {31'b0, mie_o}, 32'h0);
      csr(12'h342, 2'd0, 0);
      chk("trap_mcause", csr_rdata_o, 32'h2);
      csr(12'h300, 2'd0, 0);
      chk("trap_mstatus", csr_rdata_o, 32'h1880);
      step(12'h000, 2'd0, 0, 0, 1, 0, 0, 0, 0, '0);
      csr(12'h300, 2'd0, 0);
      chk("mret_mstatus", csr_rdata_o, 32'h1888);
      step(12'h341, 2'd1, 32'h500, 1, 0, 32'h204, 32'h7, 0, 0, '0);
      chk("trap_beats_write", mepc_o, 32'h204);
      step(12'h340, 2'd1, 32'h77, 1, 0, 32'h308, 32'h3, 0, 0, '0);
      csr(12'h340, 2'd0, 0);
      chk("trap_other_write", csr_rdata_o, 32'h77);
      csr_addr_i = 12'h340; csr_op_i = 2'd1; csr_wdata_i = 32'h1234; trap_i = 1; trap_pc_i = 32'h40;
      #2 rst_i = 1;
      #1 chk_reset("midop_reset");
      @(posedge clk_i);
      #1;
      csr_op_i = 0; trap_i = 0;
      rst_i = 0;
      m_reset();
      csr(12'h340, 2'd0, 0);
      chk("reset_discard", csr_rdata_o, 32'h0);
      for (int i = 0; i < 2000; i++) begin
         logic [11:0] a;
         logic tr, mr;
         a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 26)];
         tr = $urandom_range(0, 15) == 0;
         mr = !tr && $urandom_range(0, 15) == 0;
         step(a, 2'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom,
              tr, mr, $urandom, $urandom, $urandom, 1'($urandom), NH'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
